// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampled UART receiver with start-bit validation,
// 3-sample majority vote per bit, optional parity, and a one-entry
// valid/ready holding register that reports framing/parity/overrun.
module uart_rx_oversampled #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);
  localparam int M  = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_LO  = SW'(M - 1);
  localparam logic [SW-1:0] S_MID = SW'(M);
  localparam logic [SW-1:0] S_HI  = SW'(M + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic                 rx_s1, rxs, rxs_d;
  logic [DIV_W-1:0]     div_cnt, div_q;
  logic [SW-1:0]        s;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 v0, v1;
  logic                 par_en_q, par_odd_q;
  logic                 perr_q, ferr_q, done;
  logic                 tick, maj, decide, bit_end;

  // Divider terminal count is only meaningful while a frame is in progress.
  assign tick    = (div_cnt == div_q);
  // Third vote is the live sample taken on the deciding tick.
  assign maj     = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
  assign decide  = tick && (s == S_HI);
  assign bit_end = tick && (s == S_END);

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
      rxs_d <= rxs;
    end
  end

  // Frame FSM: tick/sample timing, majority vote, data shift, parity and stop checks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      div_q     <= '0;
      s         <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        // Only a real 1->0 transition arms; a stuck-low line stays idle.
        if (rxs_d && !rxs) begin
          state     <= START;
          div_cnt   <= '0;
          s         <= '0;
          div_q     <= baud_div;
          par_en_q  <= parity_en;
          par_odd_q <= parity_odd;
          bit_cnt   <= '0;
          perr_q    <= 1'b0;
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) s <= (s == S_END) ? '0 : s + 1'b1;
        if (tick && s == S_LO)  v0 <= rxs;
        if (tick && s == S_MID) v1 <= rxs;
        case (state)
          START: begin
            if (decide && maj) state <= IDLE;
            else if (bit_end)  state <= DATA;
          end
          DATA: begin
            if (decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (bit_end) begin
              if (bit_cnt == B_LAST) state <= par_en_q ? PARITY : STOP;
              else                   bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (decide)  perr_q <= ((^shreg) ^ maj) != par_odd_q;
            if (bit_end) state  <= STOP;
          end
          STOP: begin
            // Leave at mid-stop so the next start edge is caught promptly.
            if (decide) begin
              ferr_q <= ~maj;
              done   <= 1'b1;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Holding register: load on completion if free or draining this clk, else flag overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          frame_err  <= ferr_q;
          parity_err <= perr_q;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule
